uart_rx_mmio: RTL and testbench

//   Receive side of the board UART: deserialises an 8N1 serial line into an

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_mmio_if.sv | 35 +++
 rtl/uart_rx_fifo.sv | 58 +++++
 rtl/uart_rx_mmio.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_mmio.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: RX FSM encoding, MIO
// register addresses and status-register bit positions.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_e;

    // MIO_BUS register map
    localparam logic [15:0] UART_RX_STAT = 16'hF008;
    localparam logic [15:0] UART_RX_DATA = 16'hF00C;

    // Status register layout at UART_RX_STAT
    localparam int STAT_VALID_BIT     = 0;
    localparam int STAT_OVERRUN_BIT   = 1;
    localparam int STAT_FRAME_ERR_BIT = 2;
    localparam int STAT_COUNT_LSB     = 4;
    localparam int STAT_COUNT_MSB     = 7;

endpackage

// File: rtl/uart_rx_mmio_if.sv
// MIO_BUS side of the UART receiver: pop/clear strobes from the bus and the
// FIFO head, occupancy and sticky error flags back to it.
interface uart_rx_mmio_if #(
    parameter int DEPTH = 8
);
    logic                     uart_re;
    logic                     err_clr;
    logic [7:0]               uart_rdata;
    logic                     uart_rx_valid;
    logic                     uart_overrun;
    logic                     uart_frame_err;
    logic [$clog2(DEPTH):0]   rx_count;

    // Bus decoder side
    modport master (
        output uart_re,
        output err_clr,
        input  uart_rdata,
        input  uart_rx_valid,
        input  uart_overrun,
        input  uart_frame_err,
        input  rx_count
    );

    // Receiver side
    modport slave (
        input  uart_re,
        input  err_clr,
        output uart_rdata,
        output uart_rx_valid,
        output uart_overrun,
        output uart_frame_err,
        output rx_count
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with a show-ahead head. Occupancy counters are
// one bit wider than the address so full and empty are distinguishable.
module uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [7:0]             push_data_i,
    input  logic                   pop_i,
    output logic [7:0]             head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_cnt_q, wr_cnt_d;
    logic [AW:0] rd_cnt_q, rd_cnt_d;
    logic        pop_ok;
    logic        push_ok;

    assign count_o = wr_cnt_q - rd_cnt_q;
    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign head_o  = empty_o ? 8'h00 : mem_q[rd_cnt_q[AW-1:0]];

    // Pop is ignored when empty; a push into a full FIFO only lands when a
    // pop frees the slot in the same cycle.
    always_comb begin
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        wr_cnt_d = push_ok ? wr_cnt_q + (AW+1)'(1) : wr_cnt_q;
        rd_cnt_d = pop_ok  ? rd_cnt_q + (AW+1)'(1) : rd_cnt_q;
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Storage array write port
    // NOTE: the array has no reset; stale entries are never visible because
    // head_o is gated by empty_o, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_cnt_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver feeding a show-ahead FIFO drained over MIO_BUS.
// The serial line is double-flopped; the FSM samples mid-bit using a
// per-bit clock counter started from the detected start edge.
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    uart_rx_mmio_if.slave  bus
);
    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q;
    logic             rx_s_q;
    rx_state_e        state_q,   state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             push;
    logic             frame_err_set;
    logic             overrun_set;
    logic             fifo_full;
    logic             fifo_empty;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    // NOTE: sequential blocks use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state logic: start validation, mid-bit sampling, stop check
    // NOTE: every signal gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        clk_cnt_d     = clk_cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        push          = 1'b0;
        frame_err_set = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                if (!rx_s_q) begin
                    state_d   = RX_START;
                    clk_cnt_d = '0;
                end
            end
            RX_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = RX_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = RX_IDLE;  // too short to be a start bit
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        frame_err_set = 1'b1;
                        state_d       = RX_WAIT_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_WAIT_IDLE: begin
                // A held-low line (break) must return high before re-arming
                if (rx_s_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // A simultaneous pop frees the slot, so only an unrelieved full drops
    assign overrun_set = push && fifo_full && !bus.uart_re;

    // Sticky error flags: clear on err_clr, but a same-cycle set wins
    always_comb begin
        overrun_d   = (bus.err_clr ? 1'b0 : overrun_q)   | overrun_set;
        frame_err_d = (bus.err_clr ? 1'b0 : frame_err_q) | frame_err_set;
    end

    // Error flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (shift_q),
        .pop_i       (bus.uart_re),
        .head_o      (bus.uart_rdata),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (bus.rx_count)
    );

    assign bus.uart_rx_valid  = !fifo_empty;
    assign bus.uart_overrun   = overrun_q;
    assign bus.uart_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio: drives 8N1 frames on rx and checks the
// MIO-side outputs against a byte queue of expected FIFO contents.
module tb_uart_rx_mmio;
    import uart_pkg::*;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst;
    logic rx;

    uart_rx_mmio_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_mmio #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 8N1 frame, one bit-slot per CPB cycles. Optional: pop strobe in
    // cycle pop_at, reset in cycle rst_at, latency probes around the
    // stop-sample edge (cycle 155 relative to the start-bit drive).
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int pop_at, input int rst_at, input bit chk_lat);
        int         slot;
        logic [7:0] exp_head;
        for (int n = 0; n < FRAME; n++) begin
            @(posedge clk);
            #1;
            slot = n / CPB;
            if (slot == 0)      rx = 1'b0;
            else if (slot <= 8) rx = data[slot-1];
            else                rx = stop_bit;
            bus.uart_re = (n == pop_at);
            rst         = (n == rst_at);
            if (chk_lat && n == 154) check("count_before_push", bus.rx_count, 0);
            if (chk_lat && n == 155) check("count_after_push", bus.rx_count, 1);
            if (n == pop_at) begin
                @(negedge clk);
                exp_head = (sb.size() > 0) ? sb.pop_front() : 8'h00;
                check("pop_on_push_head", bus.uart_rdata, exp_head);
            end
        end
        bus.uart_re = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp_head;
        @(posedge clk);
        #1;
        bus.uart_re = 1'b1;
        @(negedge clk);
        exp_head = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        check(tag, bus.uart_rdata, exp_head);
        @(posedge clk);
        #1;
        bus.uart_re = 1'b0;
    endtask

    task automatic pulse_err_clr();
        @(posedge clk);
        #1;
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] stat;

        rst         = 1'b1;
        rx          = 1'b1;
        bus.uart_re = 1'b0;
        bus.err_clr = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Reset state
        check("rst_valid",     bus.uart_rx_valid, 0);
        check("rst_rdata",     bus.uart_rdata, 0);
        check("rst_count",     bus.rx_count, 0);
        check("rst_overrun",   bus.uart_overrun, 0);
        check("rst_frame_err", bus.uart_frame_err, 0);

        // Single frame with push latency probes
        send_frame(8'h55, 1'b1, -1, -1, 1'b1);
        sb.push_back(8'h55);
        check("single_valid", bus.uart_rx_valid, 1);
        check("single_rdata", bus.uart_rdata, 8'h55);
        check("single_count", bus.rx_count, 1);
        stat = 8'h00;
        stat[STAT_VALID_BIT]                    = bus.uart_rx_valid;
        stat[STAT_OVERRUN_BIT]                  = bus.uart_overrun;
        stat[STAT_FRAME_ERR_BIT]                = bus.uart_frame_err;
        stat[STAT_COUNT_MSB:STAT_COUNT_LSB]     = bus.rx_count;
        check("single_status", stat, 8'h11);
        pop_check("single_pop");
        check("single_count_after_pop", bus.rx_count, 0);
        check("single_rdata_empty", bus.uart_rdata, 0);

        // Read while empty is ignored
        pop_check("empty_read_rdata");
        check("empty_read_count", bus.rx_count, 0);
        check("empty_read_overrun", bus.uart_overrun, 0);

        // Ordering of back-to-back frames
        send_frame(8'hA3, 1'b1, -1, -1, 1'b0);
        sb.push_back(8'hA3);
        send_frame(8'h0F, 1'b1, -1, -1, 1'b0);
        sb.push_back(8'h0F);
        check("order_count", bus.rx_count, 2);
        pop_check("order_pop0");
        pop_check("order_pop1");
        check("order_count_empty", bus.rx_count, 0);

        // Short low pulse is rejected as a glitch
        @(posedge clk);
        #1;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(20);
        check("glitch_count",     bus.rx_count, 0);
        check("glitch_frame_err", bus.uart_frame_err, 0);
        check("glitch_overrun",   bus.uart_overrun, 0);
        check("glitch_state",     dut.state_q, RX_IDLE);

        // Framing error with line held low (break)
        send_frame(8'h41, 1'b0, -1, -1, 1'b0);
        idle(40);
        check("frame_err_set",   bus.uart_frame_err, 1);
        check("frame_err_count", bus.rx_count, 0);
        rx = 1'b1;
        idle(40);
        check("frame_no_retrigger", bus.rx_count, 0);
        check("frame_state_idle",   dut.state_q, RX_IDLE);
        check("frame_err_sticky",   bus.uart_frame_err, 1);
        pulse_err_clr();
        check("frame_err_cleared",  bus.uart_frame_err, 0);
        send_frame(8'h42, 1'b1, -1, -1, 1'b0);
        sb.push_back(8'h42);
        check("frame_next_count", bus.rx_count, 1);
        pop_check("frame_next_pop");

        // Overrun: nine frames into an eight-deep FIFO
        for (int i = 0; i < 9; i++) begin
            send_frame(8'h30 + 8'(i), 1'b1, -1, -1, 1'b0);
            if (sb.size() < DEPTH) sb.push_back(8'h30 + 8'(i));
            if (i == 7) check("ovr_full_no_flag", bus.uart_overrun, 0);
        end
        check("ovr_count", bus.rx_count, 8);
        check("ovr_flag",  bus.uart_overrun, 1);
        for (int i = 0; i < 8; i++) pop_check($sformatf("ovr_pop%0d", i));
        check("ovr_drained", bus.rx_count, 0);
        check("ovr_sticky",  bus.uart_overrun, 1);
        pulse_err_clr();
        check("ovr_cleared", bus.uart_overrun, 0);

        // Full FIFO with a pop on the push edge is not an overrun
        for (int i = 0; i < 8; i++) begin
            send_frame(8'h50 + 8'(i), 1'b1, -1, -1, 1'b0);
            sb.push_back(8'h50 + 8'(i));
        end
        send_frame(8'h58, 1'b1, 154, -1, 1'b0);
        sb.push_back(8'h58);
        check("popush_overrun", bus.uart_overrun, 0);
        check("popush_count",   bus.rx_count, 8);
        for (int i = 0; i < 8; i++) pop_check($sformatf("popush_pop%0d", i));

        // Reset during bit 4 of a frame, with data already buffered
        send_frame(8'h11, 1'b1, -1, -1, 1'b0);
        send_frame(8'h41, 1'b0, -1, -1, 1'b0);
        rx = 1'b1;
        idle(20);
        send_frame(8'hFF, 1'b1, -1, 5 * CPB + 5, 1'b0);
        sb.delete();
        idle(4);
        check("midrst_valid",     bus.uart_rx_valid, 0);
        check("midrst_rdata",     bus.uart_rdata, 0);
        check("midrst_count",     bus.rx_count, 0);
        check("midrst_overrun",   bus.uart_overrun, 0);
        check("midrst_frame_err", bus.uart_frame_err, 0);
        send_frame(8'h7E, 1'b1, -1, -1, 1'b0);
        sb.push_back(8'h7E);
        check("midrst_next_rdata", bus.uart_rdata, 8'h7E);
        check("midrst_next_count", bus.rx_count, 1);
        pop_check("midrst_next_pop");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
